// File: rtl/psg_pkg.sv
// Shared constants for the Sunsoft 5B-style PSG: register indices, mixer and
// envelope-shape bit positions, noise LFSR seed/tap and the log-volume DAC.
package psg_pkg;

  // Register indices (low 5 bits of the address latch)
  localparam int R_NOISE_PER = 6;
  localparam int R_MIXER_A   = 7;
  localparam int R_VOL_A     = 8;
  localparam int R_ENV_LO    = 11;
  localparam int R_ENV_HI    = 12;
  localparam int R_ENV_SHAPE = 13;
  localparam int R_TONE_B    = 16;
  localparam int R_MIXER_B   = 22;
  localparam int R_VOL_B     = 23;

  // Mixer register layout: tone disables in [2:0], noise disables in [5:3]
  localparam int MIX_TONE_DIS  = 0;
  localparam int MIX_NOISE_DIS = 3;
  localparam logic [7:0] MIXER_RESET = 8'h3F;

  // Volume register: [3:0] fixed level, [4] follow envelope
  localparam int VOL_ENV_BIT = 4;

  // Envelope shape bits
  localparam int SHAPE_HOLD = 0;
  localparam int SHAPE_ALT  = 1;
  localparam int SHAPE_ATT  = 2;
  localparam int SHAPE_CONT = 3;

  // Noise LFSR: shift right, new bit16 = b0 ^ b[LFSR_TAP]
  localparam logic [16:0] LFSR_SEED = 17'h00001;
  localparam int          LFSR_TAP  = 3;

  // Channels 0-2 live in the classic map, 3-5 in the extension block
  function automatic logic [4:0] tone_lo_reg(int ch);
    return (ch < 3) ? 5'(2 * ch) : 5'(R_TONE_B + 2 * (ch - 3));
  endfunction

  function automatic logic [4:0] tone_hi_reg(int ch);
    return tone_lo_reg(ch) + 5'd1;
  endfunction

  function automatic logic [4:0] vol_reg(int ch);
    return (ch < 3) ? 5'(R_VOL_A + ch) : 5'(R_VOL_B + ch - 3);
  endfunction

  function automatic logic [4:0] mixer_reg(int ch);
    return (ch < 3) ? 5'(R_MIXER_A) : 5'(R_MIXER_B);
  endfunction

  function automatic int mixer_bit(int ch);
    return ch % 3;
  endfunction

  // Logarithmic 4-bit volume to 8-bit amplitude
  function automatic logic [7:0] dac_level(logic [3:0] idx);
    logic [7:0] lvl;
    case (idx)
      4'd0:    lvl = 8'd0;
      4'd1:    lvl = 8'd2;
      4'd2:    lvl = 8'd3;
      4'd3:    lvl = 8'd4;
      4'd4:    lvl = 8'd6;
      4'd5:    lvl = 8'd8;
      4'd6:    lvl = 8'd11;
      4'd7:    lvl = 8'd16;
      4'd8:    lvl = 8'd23;
      4'd9:    lvl = 8'd32;
      4'd10:   lvl = 8'd45;
      4'd11:   lvl = 8'd64;
      4'd12:   lvl = 8'd90;
      4'd13:   lvl = 8'd127;
      4'd14:   lvl = 8'd180;
      default: lvl = 8'd255;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/psg_tone_ch.sv
// One square-wave tone channel: 12-bit period counter plus square flip-flop.
// Period 0 behaves as period 1; a period written below the running count
// wraps on the next tick.
module psg_tone_ch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [11:0] period,
  output logic        sq
);

  logic [11:0] cnt_q;
  logic [12:0] cnt_inc;
  logic [11:0] period_eff;
  logic        wrap;

  // Wrap when the incremented count reaches max(period, 1)
  always_comb begin
    period_eff = (period == 12'd0) ? 12'd1 : period;
    cnt_inc    = {1'b0, cnt_q} + 13'd1;
    wrap       = (cnt_inc >= {1'b0, period_eff});
  end

  // Counter and square output advance once per generator tick
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sq    <= 1'b0;
    end else if (tick) begin
      if (wrap) begin
        cnt_q <= '0;
        sq    <= ~sq;
      end else begin
        cnt_q <= cnt_inc[11:0];
      end
    end
  end

endmodule

// File: rtl/psg_5b_multi.sv
// Sunsoft 5B-style PSG with 1..6 tone channels, shared noise LFSR, log DAC
// and saturating mixer. CPU writes: $C000 latches the register address,
// $E000 writes data. All state changes on the falling edge of phi_2;
// map_enable low clears everything asynchronously.
// Optional hardware envelope: define PSG_ENVELOPE_EN. Without it regs 11-13
// are ignored and volume bit 4 has no effect.
module psg_5b_multi
  import psg_pkg::*;
#(
  parameter int CHANNELS   = 3,
  parameter int PRESCALE   = 16,
  parameter int OUT_W      = 12,
  parameter int GAIN_SHIFT = 2
) (
  input  logic             phi_2,
  input  logic             map_enable,
  input  logic [7:0]       cpu_d,
  input  logic [4:0]       cpu_a,
  input  logic             cpu_ce_n,
  input  logic             cpu_rw,
  output logic [OUT_W-1:0] audio_out
);

  localparam int PRE_W = $clog2(PRESCALE);
  localparam int SUM_W = 11;
  localparam logic [31:0] OUT_MAX = 32'((64'd1 << OUT_W) - 64'd1);

  logic [7:0]       regs_q [32];
  logic [4:0]       raddr_q;
  logic             addr_wr;
  logic             data_wr;
  logic             write_ok;
  logic [PRE_W-1:0] presc_q;
  logic             tick;
  logic             noise;
  logic             unused_bits;

  assign unused_bits = ^cpu_a[2:0];

  // Registers that exist in this build; absent channels ignore writes
  function automatic logic reg_writable(logic [4:0] a);
    logic ok;
    ok = 1'b0;
    if (a <= 5'd5)
      ok = (int'(a >> 1) < CHANNELS);
    else if (a == 5'd6 || a == 5'd7)
      ok = 1'b1;
    else if (a >= 5'd8 && a <= 5'd10)
      ok = (int'(a - 5'd8) < CHANNELS);
`ifdef PSG_ENVELOPE_EN
    else if (a >= 5'd11 && a <= 5'd13)
      ok = 1'b1;
`endif
    else if (a >= 5'd16 && a <= 5'd21)
      ok = (3 + int'((a - 5'd16) >> 1) < CHANNELS);
    else if (a == 5'd22)
      ok = (CHANNELS > 3);
    else if (a >= 5'd23 && a <= 5'd25)
      ok = (3 + int'(a - 5'd23) < CHANNELS);
    return ok;
  endfunction

  // CPU bus decode: A14..A13 = 2 latches address, 3 writes data
  always_comb begin
    addr_wr  = !cpu_ce_n && !cpu_rw && (cpu_a[4:3] == 2'd2);
    data_wr  = !cpu_ce_n && !cpu_rw && (cpu_a[4:3] == 2'd3);
    write_ok = data_wr && reg_writable(raddr_q);
  end

  // Address latch and register file; mixers reset to all-disabled
  always_ff @(negedge phi_2 or negedge map_enable) begin
    if (!map_enable) begin
      raddr_q <= '0;
      for (int i = 0; i < 32; i++)
        regs_q[i] <= (i == R_MIXER_A || i == R_MIXER_B) ? MIXER_RESET : 8'h00;
    end else begin
      if (addr_wr)
        raddr_q <= cpu_d[4:0];
      if (write_ok)
        regs_q[raddr_q] <= cpu_d;
    end
  end

  assign tick = (presc_q == PRE_W'(PRESCALE - 1));

  // Prescaler: one generator tick every PRESCALE phi_2 cycles
  always_ff @(negedge phi_2 or negedge map_enable) begin
    if (!map_enable)
      presc_q <= '0;
    else
      presc_q <= tick ? '0 : presc_q + PRE_W'(1);
  end

  // ---------------- noise ----------------
  logic [4:0]  ncnt_q;
  logic [16:0] lfsr_q;
  logic [4:0]  nper_eff;
  logic        nwrap;

  always_comb begin
    nper_eff = (regs_q[R_NOISE_PER][4:0] == 5'd0) ? 5'd1 : regs_q[R_NOISE_PER][4:0];
    nwrap    = ({1'b0, ncnt_q} + 6'd1) >= {1'b0, nper_eff};
  end

  // Noise period counter; LFSR steps at each wrap
  always_ff @(negedge phi_2 or negedge map_enable) begin
    if (!map_enable) begin
      ncnt_q <= '0;
      lfsr_q <= LFSR_SEED;
    end else if (tick) begin
      if (nwrap) begin
        ncnt_q <= '0;
        lfsr_q <= {lfsr_q[0] ^ lfsr_q[LFSR_TAP], lfsr_q[16:1]};
      end else begin
        ncnt_q <= ncnt_q + 5'd1;
      end
    end
  end

  assign noise = lfsr_q[0];

`ifdef PSG_ENVELOPE_EN
  // ---------------- envelope ----------------
  logic [15:0] ecnt_q;
  logic [3:0]  estep_q;
  logic        eatt_q;
  logic        ehold_q;
  logic [3:0]  ehold_lvl_q;
  logic [15:0] eper_eff;
  logic        ewrap;
  logic        erestart;
  logic [3:0]  shape;
  logic [3:0]  env_level;

  always_comb begin
    eper_eff  = ({regs_q[R_ENV_HI], regs_q[R_ENV_LO]} == 16'd0) ? 16'd1
                : {regs_q[R_ENV_HI], regs_q[R_ENV_LO]};
    ewrap     = ({1'b0, ecnt_q} + 17'd1) >= {1'b0, eper_eff};
    erestart  = write_ok && (raddr_q == 5'(R_ENV_SHAPE));
    shape     = regs_q[R_ENV_SHAPE][3:0];
    env_level = ehold_q ? ehold_lvl_q : (eatt_q ? estep_q : ~estep_q);
  end

  // Envelope stepping; a shape write restarts and wins over a same-cycle wrap
  always_ff @(negedge phi_2 or negedge map_enable) begin
    if (!map_enable) begin
      ecnt_q      <= '0;
      estep_q     <= '0;
      eatt_q      <= 1'b0;
      ehold_q     <= 1'b0;
      ehold_lvl_q <= '0;
    end else if (erestart) begin
      ecnt_q      <= '0;
      estep_q     <= '0;
      eatt_q      <= cpu_d[SHAPE_ATT];
      ehold_q     <= 1'b0;
      ehold_lvl_q <= '0;
    end else if (tick) begin
      if (ewrap) begin
        ecnt_q <= '0;
        if (!ehold_q) begin
          if (estep_q != 4'd15) begin
            estep_q <= estep_q + 4'd1;
          end else if (!shape[SHAPE_CONT]) begin
            ehold_q     <= 1'b1;
            ehold_lvl_q <= 4'd0;
          end else if (shape[SHAPE_HOLD]) begin
            ehold_q     <= 1'b1;
            ehold_lvl_q <= (eatt_q ^ shape[SHAPE_ALT]) ? 4'd15 : 4'd0;
          end else if (shape[SHAPE_ALT]) begin
            eatt_q  <= ~eatt_q;
            estep_q <= 4'd0;
          end else begin
            estep_q <= 4'd0;
          end
        end
      end else begin
        ecnt_q <= ecnt_q + 16'd1;
      end
    end
  end
`endif

  // ---------------- tone channels and per-channel level ----------------
  logic [CHANNELS-1:0] sq;
  logic [7:0]          ch_level [CHANNELS];

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [11:0] period;
    logic [7:0]  vol;
    logic [3:0]  lvl_idx;
    logic        tone_dis;
    logic        noise_dis;
    logic        gate;

    assign period    = {regs_q[tone_hi_reg(ch)][3:0], regs_q[tone_lo_reg(ch)]};
    assign vol       = regs_q[vol_reg(ch)];
    assign tone_dis  = regs_q[mixer_reg(ch)][MIX_TONE_DIS + mixer_bit(ch)];
    assign noise_dis = regs_q[mixer_reg(ch)][MIX_NOISE_DIS + mixer_bit(ch)];
    assign gate      = (sq[ch] | tone_dis) & (noise | noise_dis);
`ifdef PSG_ENVELOPE_EN
    assign lvl_idx   = vol[VOL_ENV_BIT] ? env_level : vol[3:0];
`else
    assign lvl_idx   = vol[3:0];
`endif
    assign ch_level[ch] = gate ? dac_level(lvl_idx) : 8'd0;

    psg_tone_ch u_tone (
      .clk    (phi_2),
      .rst_n  (map_enable),
      .tick   (tick),
      .period (period),
      .sq     (sq[ch])
    );
  end

  // ---------------- mixer ----------------
  logic [SUM_W-1:0] sum;
  logic [31:0]      shifted;
  logic [OUT_W-1:0] audio_next;

  // Sum channel levels, apply gain, saturate to the output range
  always_comb begin
    sum = '0;
    for (int ch = 0; ch < CHANNELS; ch++)
      sum = sum + SUM_W'(ch_level[ch]);
    shifted    = 32'(sum) << GAIN_SHIFT;
    audio_next = (shifted > OUT_MAX) ? OUT_MAX[OUT_W-1:0] : shifted[OUT_W-1:0];
  end

  // Registered audio output
  always_ff @(negedge phi_2 or negedge map_enable) begin
    if (!map_enable)
      audio_out <= '0;
    else
      audio_out <= audio_next;
  end

endmodule
